// File: rtl/cram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cram_arbiter
// Desc     : Shares the cellular-RAM word port between the buffered ROM
//            download byte writer and the single-outstanding sample reader.
//            Optional one-word read cache: define CRAM_ARB_WORD_CACHE_EN.
// Revision : 1.0  initial release
// ============================================================================
module cram_arbiter #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [21:0] SAMPLE_BASE = 22'h100000,
    parameter int          HI_WATER    = FIFO_DEPTH - 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_wr,
    input  logic [24:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [21:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        ovf
);

    localparam int              c_aw       = $clog2(FIFO_DEPTH);
    localparam int              c_cw       = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth    = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_hi_water = c_cw'(HI_WATER);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_read  = 2'd2;

    // Write FIFO: each entry is {byte address[22:0], data[7:0]}
    logic [30:0]     r_fifo [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic [1:0]  r_state;
    logic [15:0] r_rd_addr;
    logic        r_rd_busy;
    logic        r_rd_valid;
    logic [7:0]  r_rd_data;
    logic        r_mem_req;
    logic        r_mem_wr;
    logic [21:0] r_mem_addr;
    logic [1:0]  r_mem_be;
    logic [15:0] r_mem_wdata;
    logic        r_ovf;

    logic        w_full;
    logic        w_addr_ok;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_rd_accept;
    logic        w_go_write;
    logic        w_cache_hit;
    logic [30:0] w_head;
    logic [22:0] w_head_addr;
    logic [7:0]  w_head_data;
    logic [21:0] w_rd_word;
    logic [15:0] w_hit_word;

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

    assign w_full      = (r_count == c_depth);
    assign w_addr_ok   = (ld_addr[24:23] == 2'b00);
    assign w_push      = ld_wr && w_addr_ok && !w_full;
    assign w_drop      = ld_wr && (!w_addr_ok || w_full);
    assign w_pop       = (r_state == c_st_write) && mem_ack;
    assign w_rd_accept = rd_req && !r_rd_busy;

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_head_addr = w_head[30:8];
    assign w_head_data = w_head[7:0];

    // Word address wraps modulo 2^22 by construction of the 22-bit sum
    assign w_rd_word   = SAMPLE_BASE + {7'd0, r_rd_addr[15:1]};

    // Decisions use registered occupancy only; same-cycle pushes are not seen
    assign w_go_write  = (r_count != '0) && ((r_count >= c_hi_water) || !r_rd_busy);

`ifdef CRAM_ARB_WORD_CACHE_EN
    logic        r_cache_valid;
    logic [21:0] r_cache_addr;
    logic [15:0] r_cache_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_valid <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_data  <= '0;
        end else if ((r_state == c_st_read) && mem_ack) begin
            r_cache_valid <= 1'b1;
            r_cache_addr  <= r_mem_addr;
            r_cache_data  <= mem_rdata;
        end else if (w_pop && (r_cache_addr == r_mem_addr)) begin
            r_cache_valid <= 1'b0;
        end
    end

    assign w_cache_hit = r_cache_valid && (r_cache_addr == w_rd_word);
    assign w_hit_word  = r_cache_data;
`else
    assign w_cache_hit = 1'b0;
    assign w_hit_word  = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {ld_addr[22:0], ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_rd_addr   <= '0;
            r_rd_busy   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_rd_accept) begin
                r_rd_addr <= rd_addr;
                r_rd_busy <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_go_write) begin
                        r_state     <= c_st_write;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= w_head_addr[22:1];
                        r_mem_be    <= w_head_addr[0] ? 2'b10 : 2'b01;
                        r_mem_wdata <= {w_head_data, w_head_data};
                    end else if (r_rd_busy) begin
                        if (w_cache_hit) begin
                            r_rd_data  <= pick_byte(w_hit_word, r_rd_addr[0]);
                            r_rd_valid <= 1'b1;
                            r_rd_busy  <= 1'b0;
                        end else begin
                            r_state    <= c_st_read;
                            r_mem_req  <= 1'b1;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= w_rd_word;
                            r_mem_be   <= 2'b11;
                        end
                    end
                end
                c_st_write: begin
                    if (mem_ack) begin
                        r_state   <= c_st_idle;
                        r_mem_req <= 1'b0;
                    end
                end
                c_st_read: begin
                    if (mem_ack) begin
                        r_state    <= c_st_idle;
                        r_mem_req  <= 1'b0;
                        r_rd_data  <= pick_byte(mem_rdata, r_rd_addr[0]);
                        r_rd_valid <= 1'b1;
                        r_rd_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign rd_busy   = r_rd_busy;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign mem_req   = r_mem_req;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cram_arbiter
// Desc     : Directed self-checking bench for cram_arbiter with a simple
//            cram responder and a transaction log.
// Revision : 1.0  initial release
// ============================================================================
module tb_cram_arbiter;

    logic        clk;
    logic        reset;
    logic        ld_wr;
    logic [24:0] ld_addr;
    logic [7:0]  ld_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_busy;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        mem_req;
    logic        mem_wr;
    logic [21:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ovf;

    int n_checks;
    int n_pass;
    int ack_delay;
    bit ack_hold;

    int cyc;
    int req_start;
    bit req_active;
    bit req_acked;

    int          rv_count = 0;
    logic        log_wr    [$];
    logic [21:0] log_addr  [$];
    logic [1:0]  log_be    [$];
    logic [15:0] log_wdata [$];

    cram_arbiter u_dut (
        .clk       (clk),
        .reset     (reset),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cram responder: acks ack_delay cycles after mem_req is first seen
    initial begin
        mem_ack    = 1'b0;
        cyc        = 0;
        req_start  = 0;
        req_active = 1'b0;
        req_acked  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_ack = 1'b0;
            if (reset || !mem_req) begin
                req_active = 1'b0;
                req_acked  = 1'b0;
            end else if (!req_acked) begin
                if (!req_active || ack_hold) begin
                    req_active = 1'b1;
                    req_start  = cyc;
                end
                if (!ack_hold && (cyc == req_start + ack_delay)) begin
                    mem_ack   = 1'b1;
                    req_acked = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid) rv_count++;
        if (mem_req && mem_ack && !reset) begin
            log_wr.push_back(mem_wr);
            log_addr.push_back(mem_addr);
            log_be.push_back(mem_be);
            log_wdata.push_back(mem_wdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ld_wr    = 1'b0;
        rd_req   = 1'b0;
        ack_hold = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic ld_write(input logic [24:0] a, input logic [7:0] d);
        ld_wr   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick(1);
        ld_wr = 1'b0;
    endtask

    task automatic rd_request(input logic [15:0] off);
        rd_req  = 1'b1;
        rd_addr = off;
        tick(1);
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_checks++; if ({mem_req, mem_wr, mem_be, rd_busy, rd_valid, ovf} !== 7'b0) $display("FAIL reset_ctrl: got %b expected 0000000", {mem_req, mem_wr, mem_be, rd_busy, rd_valid, ovf}); else n_pass++;
        n_checks++; if (mem_addr !== 22'h0) $display("FAIL reset_addr: got %h expected 000000", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 16'h0) $display("FAIL reset_wdata: got %h expected 0000", mem_wdata); else n_pass++;
        n_checks++; if (rd_data !== 8'h0) $display("FAIL reset_rd_data: got %h expected 00", rd_data); else n_pass++;
        reset = 1'b0;
        tick(3);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_idle_req: got %b expected 0", mem_req); else n_pass++;
    endtask

    task automatic test_write();
        int b;
        do_reset();
        ack_delay = 2;
        b = log_wr.size();
        ld_write(25'h000005, 8'hA5);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL write_req_c1: got %b expected 0", mem_req); else n_pass++;
        tick(1);
        n_checks++; if ({mem_req, mem_wr} !== 2'b11) $display("FAIL write_req_c2: got %b expected 11", {mem_req, mem_wr}); else n_pass++;
        n_checks++; if (mem_addr !== 22'h000002) $display("FAIL write_addr: got %h expected 000002", mem_addr); else n_pass++;
        n_checks++; if (mem_be !== 2'b10) $display("FAIL write_be: got %b expected 10", mem_be); else n_pass++;
        n_checks++; if (mem_wdata !== 16'hA5A5) $display("FAIL write_wdata: got %h expected a5a5", mem_wdata); else n_pass++;
        tick(2);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL write_req_c4: got %b expected 1", mem_req); else n_pass++;
        tick(1);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL write_req_c5: got %b expected 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 22'h000002) $display("FAIL write_addr_hold: got %h expected 000002", mem_addr); else n_pass++;
        tick(6);
        n_checks++; if (log_wr.size() - b !== 1) $display("FAIL write_count: got %0d expected 1", log_wr.size() - b); else n_pass++;
        n_checks++; if ({mem_req, ovf} !== 2'b00) $display("FAIL write_after: got %b expected 00", {mem_req, ovf}); else n_pass++;
    endtask

    task automatic test_read();
        do_reset();
        ack_delay = 3;
        mem_rdata = 16'h1234;
        rd_request(16'h0003);
        for (int k = 1; k <= 6; k++) begin
            n_checks++; if (rd_busy !== (k <= 5)) $display("FAIL read_busy c%0d: got %b expected %b", k, rd_busy, (k <= 5)); else n_pass++;
            n_checks++; if (rd_valid !== (k == 6)) $display("FAIL read_valid c%0d: got %b expected %b", k, rd_valid, (k == 6)); else n_pass++;
            if (k == 2) begin
                n_checks++; if ({mem_req, mem_wr, mem_be} !== 4'b1011) $display("FAIL read_ctrl: got %b expected 1011", {mem_req, mem_wr, mem_be}); else n_pass++;
                n_checks++; if (mem_addr !== 22'h100001) $display("FAIL read_addr: got %h expected 100001", mem_addr); else n_pass++;
            end
            if (k == 6) begin
                n_checks++; if (rd_data !== 8'h12) $display("FAIL read_data: got %h expected 12", rd_data); else n_pass++;
            end
            if (k < 6) tick(1);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_req [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        ack_delay = 1;
        ld_write(25'h000050, 8'h12);
        ld_write(25'h000053, 8'h34);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (mem_req !== exp_req[k]) $display("FAIL b2b_req c%0d: got %b expected %b", k + 2, mem_req, exp_req[k]); else n_pass++;
            if (k == 0) begin
                n_checks++; if ({mem_addr, mem_be, mem_wdata} !== {22'h28, 2'b01, 16'h1212}) $display("FAIL b2b_first: got %h/%b/%h expected 000028/01/1212", mem_addr, mem_be, mem_wdata); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if ({mem_addr, mem_be, mem_wdata} !== {22'h29, 2'b10, 16'h3434}) $display("FAIL b2b_second: got %h/%b/%h expected 000029/10/3434", mem_addr, mem_be, mem_wdata); else n_pass++;
            end
            tick(1);
        end
    endtask

    task automatic test_overflow();
        int          b;
        logic [21:0] ea [4] = '{22'h8, 22'h8, 22'h9, 22'h9};
        logic [1:0]  eb [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [15:0] ed [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        do_reset();
        ack_delay = 1;
        ack_hold  = 1'b1;
        b = log_wr.size();
        ld_write(25'h10, 8'h01);
        ld_write(25'h11, 8'h02);
        ld_write(25'h12, 8'h03);
        ld_write(25'h13, 8'h04);
        n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_before: got %b expected 0", ovf); else n_pass++;
        ld_write(25'h14, 8'h05);
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b expected 1", ovf); else n_pass++;
        tick(2);
        ack_hold = 1'b0;
        tick(30);
        n_checks++; if (log_wr.size() - b !== 4) $display("FAIL ovf_count: got %0d expected 4", log_wr.size() - b); else n_pass++;
        if (log_wr.size() - b >= 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if ({log_wr[b + i], log_addr[b + i], log_be[b + i], log_wdata[b + i]} !== {1'b1, ea[i], eb[i], ed[i]}) $display("FAIL ovf_order %0d: got %b/%h/%b/%h expected 1/%h/%b/%h", i, log_wr[b + i], log_addr[b + i], log_be[b + i], log_wdata[b + i], ea[i], eb[i], ed[i]); else n_pass++;
            end
        end
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf); else n_pass++;
    endtask

    task automatic test_priority();
        int          b;
        int          r;
        logic        ew [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [21:0] ea [5] = '{22'h10, 22'h11, 22'h100002, 22'h12, 22'h13};
        logic        fw [3] = '{1'b1, 1'b0, 1'b1};
        logic [21:0] fa [3] = '{22'h18, 22'h100002, 22'h19};
        // One write in flight plus three buffered, with a read pending
        do_reset();
        ack_delay = 1;
        ack_hold  = 1'b1;
        mem_rdata = 16'hBEEF;
        b = log_wr.size();
        r = rv_count;
        ld_write(25'h20, 8'h11);
        ld_write(25'h22, 8'h22);
        ld_write(25'h24, 8'h33);
        ld_write(25'h26, 8'h44);
        rd_request(16'h0004);
        tick(2);
        n_checks++; if (ovf !== 1'b0) $display("FAIL prio_full_ovf: got %b expected 0", ovf); else n_pass++;
        ack_hold = 1'b0;
        tick(40);
        n_checks++; if (log_wr.size() - b !== 5) $display("FAIL prio_hi_count: got %0d expected 5", log_wr.size() - b); else n_pass++;
        if (log_wr.size() - b >= 5) begin
            for (int i = 0; i < 5; i++) begin
                n_checks++; if ({log_wr[b + i], log_addr[b + i]} !== {ew[i], ea[i]}) $display("FAIL prio_hi_order %0d: got %b/%h expected %b/%h", i, log_wr[b + i], log_addr[b + i], ew[i], ea[i]); else n_pass++;
            end
        end
        n_checks++; if ({rv_count - r, 24'(rd_data)} !== {32'd1, 24'hEF}) $display("FAIL prio_hi_rd: got %0d/%h expected 1/ef", rv_count - r, rd_data); else n_pass++;

        // One write in flight plus one buffered: read goes first
        do_reset();
        ack_hold  = 1'b1;
        mem_rdata = 16'h9A00;
        b = log_wr.size();
        ld_write(25'h30, 8'h55);
        ld_write(25'h32, 8'h66);
        rd_request(16'h0005);
        tick(2);
        ack_hold = 1'b0;
        tick(30);
        n_checks++; if (log_wr.size() - b !== 3) $display("FAIL prio_lo_count: got %0d expected 3", log_wr.size() - b); else n_pass++;
        if (log_wr.size() - b >= 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if ({log_wr[b + i], log_addr[b + i]} !== {fw[i], fa[i]}) $display("FAIL prio_lo_order %0d: got %b/%h expected %b/%h", i, log_wr[b + i], log_addr[b + i], fw[i], fa[i]); else n_pass++;
            end
        end
        n_checks++; if (rd_data !== 8'h9A) $display("FAIL prio_lo_rd: got %h expected 9a", rd_data); else n_pass++;
    endtask

    task automatic test_bad_addr();
        int b;
        do_reset();
        ack_delay = 1;
        b = log_wr.size();
        ld_write(25'h1000000, 8'h77);
        n_checks++; if (ovf !== 1'b1) $display("FAIL bad_addr_ovf: got %b expected 1", ovf); else n_pass++;
        tick(6);
        n_checks++; if (log_wr.size() - b !== 0) $display("FAIL bad_addr_push: got %0d writes expected 0", log_wr.size() - b); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL bad_addr_req: got %b expected 0", mem_req); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int b;
        int r;
        do_reset();
        ack_delay = 2;
        mem_rdata = 16'hCAFE;
        b = log_wr.size();
        r = rv_count;
        rd_request(16'h0002);
        n_checks++; if (rd_busy !== 1'b1) $display("FAIL busy_set: got %b expected 1", rd_busy); else n_pass++;
        rd_request(16'h0101);
        tick(15);
        n_checks++; if (rv_count - r !== 1) $display("FAIL busy_valid_count: got %0d expected 1", rv_count - r); else n_pass++;
        n_checks++; if (rd_data !== 8'hFE) $display("FAIL busy_rd_data: got %h expected fe", rd_data); else n_pass++;
        n_checks++; if (log_wr.size() - b !== 1) $display("FAIL busy_reads: got %0d expected 1", log_wr.size() - b); else n_pass++;
        if (log_wr.size() - b >= 1) begin
            n_checks++; if (log_addr[b] !== 22'h100001) $display("FAIL busy_addr: got %h expected 100001", log_addr[b]); else n_pass++;
        end
        n_checks++; if (rd_busy !== 1'b0) $display("FAIL busy_clear: got %b expected 0", rd_busy); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int b;
        do_reset();
        ack_delay = 1;
        ack_hold  = 1'b1;
        b = log_wr.size();
        ld_write(25'h40, 8'h99);
        tick(2);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL midrst_req_before: got %b expected 1", mem_req); else n_pass++;
        reset = 1'b1;
        tick(1);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL midrst_req_drop: got %b expected 0", mem_req); else n_pass++;
        tick(1);
        reset    = 1'b0;
        ack_hold = 1'b0;
        tick(8);
        n_checks++; if ({mem_req, ovf, rd_busy} !== 3'b000) $display("FAIL midrst_idle: got %b expected 000", {mem_req, ovf, rd_busy}); else n_pass++;
        n_checks++; if (log_wr.size() - b !== 0) $display("FAIL midrst_txn: got %0d expected 0", log_wr.size() - b); else n_pass++;
    endtask

`ifdef CRAM_ARB_WORD_CACHE_EN
    task automatic test_cache();
        int b;
        do_reset();
        ack_delay = 1;
        mem_rdata = 16'h5A3C;
        b = log_wr.size();
        rd_request(16'h0010);
        tick(8);
        rd_request(16'h0011);
        n_checks++; if ({rd_valid, rd_busy} !== 2'b01) $display("FAIL cache_c1: got %b expected 01", {rd_valid, rd_busy}); else n_pass++;
        tick(1);
        n_checks++; if ({rd_valid, rd_busy, mem_req} !== 3'b100) $display("FAIL cache_c2: got %b expected 100", {rd_valid, rd_busy, mem_req}); else n_pass++;
        n_checks++; if (rd_data !== 8'h5A) $display("FAIL cache_hit_data: got %h expected 5a", rd_data); else n_pass++;
        tick(3);
        n_checks++; if (log_wr.size() - b !== 1) $display("FAIL cache_one_read: got %0d expected 1", log_wr.size() - b); else n_pass++;
        ld_write(25'h0200010, 8'hEE);
        tick(8);
        mem_rdata = 16'h7781;
        rd_request(16'h0011);
        tick(10);
        n_checks++; if (log_wr.size() - b !== 3) $display("FAIL cache_refetch: got %0d expected 3", log_wr.size() - b); else n_pass++;
        if (log_wr.size() - b >= 3) begin
            n_checks++; if ({log_wr[b + 2], log_addr[b + 2]} !== {1'b0, 22'h100008}) $display("FAIL cache_refetch_addr: got %b/%h expected 0/100008", log_wr[b + 2], log_addr[b + 2]); else n_pass++;
        end
        n_checks++; if (rd_data !== 8'h77) $display("FAIL cache_new_data: got %h expected 77", rd_data); else n_pass++;
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        ld_wr     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        mem_rdata = '0;
        ack_delay = 1;
        ack_hold  = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_overflow();
        test_priority();
        test_bad_addr();
        test_busy_ignore();
        test_mid_reset();
`ifdef CRAM_ARB_WORD_CACHE_EN
        test_cache();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
